// File: rtl/jts16_mixer_n_pkg.sv
// jts16_mix_pkg: rank constants, special addresses/colours and layer field geometry for the mixer
package jts16_mix_pkg;
    localparam logic [3:0]  RK_FIX_HI  = 4'd14;
    localparam logic [3:0]  RK_FIX_LO  = 4'd6;
    localparam int          RK_SCR_HI  = 12;
    localparam int          RK_SCR_LO  = 4;
    localparam logic [10:0] BACKDROP   = 11'h400;
    localparam logic [3:0]  SHADOW_COL = 4'hE;
    localparam int          SCR_W      = 11;
    localparam int          CHAR_W     = 7;
    localparam int          OBJ_W      = 12;

    function automatic logic [3:0] scr_rank(input logic prio, input int i);
        return prio ? 4'(RK_SCR_HI - 2 * i) : 4'(RK_SCR_LO - i);
    endfunction
endpackage

// File: rtl/jts16_mixer_n_if.sv
// jts16_mixer_n_if: pixel inputs, mixed output and statistics port of the layer mixer
interface jts16_mixer_n_if #(parameter int NSCR = 2);
    logic                  pxl_cen;
    logic                  lvbl;
    logic [6:0]            char_pxl;
    logic [NSCR*11-1:0]    scr_pxl;
    logic [11:0]           obj_pxl;
    logic                  set_fix;
    logic [NSCR+1:0]       gfx_en;
    logic [10:0]           pal_addr;
    logic                  shadow;
    logic [NSCR+1:0]       sel;
    logic [7:0]            st_addr;
    logic [7:0]            st_dout;

    modport master(output pxl_cen, lvbl, char_pxl, scr_pxl, obj_pxl, set_fix, gfx_en, st_addr,
                   input pal_addr, shadow, sel, st_dout);
    modport slave(input pxl_cen, lvbl, char_pxl, scr_pxl, obj_pxl, set_fix, gfx_en, st_addr,
                  output pal_addr, shadow, sel, st_dout);
endinterface

// File: rtl/jts16_mixer_stats.sv
// jts16_mixer_stats: per-frame saturating winner counters latched on the lvbl falling edge
module jts16_mixer_stats import jts16_mix_pkg::*; #(
    parameter int NSCR = 2,
    parameter int CNTW = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen_i,
    input  logic            lvbl_i,
    input  logic [NSCR+1:0] sel_i,
    input  logic [7:0]      st_addr_i,
    output logic [7:0]      st_dout_o
);
    localparam int NC = NSCR + 3;
    logic [CNTW-1:0] live_q [NC];
    logic [CNTW-1:0] live_d [NC];
    logic [CNTW-1:0] lat_q  [NC];
    logic            lvbl_q;
    logic            fall;
    logic [2:0]      idx;
    logic [31:0]     word;

    assign fall = lvbl_q & ~lvbl_i;

    // backdrop owns the last counter
    always_comb begin
        idx = 3'(NC - 1);
        for (int i = 0; i < NSCR + 2; i++) idx = sel_i[i] ? 3'(i) : idx;
        for (int c = 0; c < NC; c++)
            live_d[c] = (cen_i && lvbl_i && idx == 3'(c) && !(&live_q[c])) ? live_q[c] + CNTW'(1) : live_q[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvbl_q <= 1'b0;
            for (int c = 0; c < NC; c++) begin
                live_q[c] <= '0;
                lat_q[c]  <= '0;
            end
        end else begin
            lvbl_q <= lvbl_i;
            for (int c = 0; c < NC; c++) begin
                live_q[c] <= fall ? '0 : live_d[c];
                if (fall) lat_q[c] <= live_d[c];
            end
        end
    end

    always_comb begin
        word = '0;
        for (int c = 0; c < NC; c++) word = (st_addr_i[7:2] == 6'(c)) ? 32'(lat_q[c]) : word;
        st_dout_o = word[{st_addr_i[1:0], 3'b000} +: 8];
    end
endmodule

// File: rtl/jts16_mixer_n.sv
// jts16_mixer_n: two-stage fix/obj/scroll priority mixer with optional output delay and winner stats
module jts16_mixer_n import jts16_mix_pkg::*; #(
    parameter int NSCR  = 2,
    parameter int EXTRA = 0,
    parameter int CNTW  = 17
) (
    input logic             clk,
    input logic             rst,
    jts16_mixer_n_if.slave  mix_if
);
    localparam int NL = NSCR + 2;
    localparam int OW = 11 + 1 + NL;

    logic [CHAR_W-1:0]      char_q;
    logic [NSCR*SCR_W-1:0]  scr_q;
    logic [OBJ_W-1:0]       obj_q;
    logic                   set_fix_q;
    logic [NL-1:0]          gfx_en_q;
    logic [OW-1:0]          dly_q [EXTRA+1];
    logic [3:0]             rank [NL];
    logic [10:0]            addr [NL];
    logic [NL-1:0]          opq;
    logic [3:0]             win_rk;
    logic [10:0]            win_addr;
    logic [NL-1:0]          win_sel;
    logic                   shd;

    always_comb begin
        rank[0] = (char_q[6] | set_fix_q) ? RK_FIX_HI : RK_FIX_LO;
        addr[0] = {1'b1, 4'd0, char_q[5:0]};
        opq[0]  = gfx_en_q[0] & (|char_q[2:0]);
        rank[1] = {obj_q[11:10], 2'b01};
        addr[1] = {1'b0, obj_q[9:0]};
        opq[1]  = gfx_en_q[1] & (|obj_q[3:0]) & (obj_q[3:0] != SHADOW_COL);
        for (int i = 0; i < NSCR; i++) begin
            rank[i+2] = scr_rank(scr_q[SCR_W*i+10], i);
            addr[i+2] = {1'b1, scr_q[SCR_W*i +: 10]};
            opq[i+2]  = gfx_en_q[i+2] & (|scr_q[SCR_W*i +: 3]);
        end
    end

    // strict compare walking up the index keeps the lowest index on ties
    always_comb begin
        win_rk   = '0;
        win_addr = BACKDROP;
        win_sel  = '0;
        for (int i = 0; i < NL; i++) begin
            if (opq[i] && rank[i] > win_rk) begin
                win_rk     = rank[i];
                win_addr   = addr[i];
                win_sel    = '0;
                win_sel[i] = 1'b1;
            end
        end
        shd = gfx_en_q[1] && (obj_q[3:0] == SHADOW_COL) && (rank[1] > win_rk);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_q    <= '0;
            scr_q     <= '0;
            obj_q     <= '0;
            set_fix_q <= 1'b0;
            gfx_en_q  <= '0;
            for (int k = 0; k <= EXTRA; k++) dly_q[k] <= '0;
        end else if (mix_if.pxl_cen) begin
            char_q    <= mix_if.char_pxl;
            scr_q     <= mix_if.scr_pxl;
            obj_q     <= mix_if.obj_pxl;
            set_fix_q <= mix_if.set_fix;
            gfx_en_q  <= mix_if.gfx_en;
            dly_q[0]  <= {win_addr, shd, win_sel};
            for (int k = 1; k <= EXTRA; k++) dly_q[k] <= dly_q[k-1];
        end
    end

    assign {mix_if.pal_addr, mix_if.shadow, mix_if.sel} = dly_q[EXTRA];

    jts16_mixer_stats #(.NSCR(NSCR), .CNTW(CNTW)) u_stats (
        .clk       (clk),
        .rst       (rst),
        .cen_i     (mix_if.pxl_cen),
        .lvbl_i    (mix_if.lvbl),
        .sel_i     (dly_q[0][NL-1:0]),
        .st_addr_i (mix_if.st_addr),
        .st_dout_o (mix_if.st_dout)
    );
endmodule

// File: tb/tb_jts16_mixer_n.sv
// tb_jts16_mixer_n: directed vectors for priority, shadow, ties, backdrop and frame statistics
module tb_jts16_mixer_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    jts16_mixer_n_if #(.NSCR(2)) a_if();
    jts16_mixer_n_if #(.NSCR(4)) b_if();

    jts16_mixer_n #(.NSCR(2)) dut_a (.clk(clk), .rst(rst), .mix_if(a_if.slave));
    jts16_mixer_n #(.NSCR(4), .CNTW(4)) dut_b (.clk(clk), .rst(rst), .mix_if(b_if.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        a_if.pxl_cen = 1'b1;
        b_if.pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        a_if.pxl_cen = 1'b0;
        b_if.pxl_cen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [10:0] pa, input logic [3:0] s, input logic sh);
        tick();
        tick();
        chk({tag, ".pal"}, 32'(a_if.pal_addr), 32'(pa));
        chk({tag, ".sel"}, 32'(a_if.sel), 32'(s));
        chk({tag, ".shd"}, 32'(a_if.shadow), 32'(sh));
    endtask

    task automatic chk_b(input string tag, input logic [10:0] pa, input logic [5:0] s);
        tick();
        tick();
        chk({tag, ".pal"}, 32'(b_if.pal_addr), 32'(pa));
        chk({tag, ".sel"}, 32'(b_if.sel), 32'(s));
    endtask

    initial begin
        a_if.pxl_cen = 0; a_if.lvbl = 0; a_if.char_pxl = 0; a_if.scr_pxl = 0; a_if.obj_pxl = 0;
        a_if.set_fix = 0; a_if.gfx_en = '1; a_if.st_addr = 0;
        b_if.pxl_cen = 0; b_if.lvbl = 0; b_if.char_pxl = 0; b_if.scr_pxl = 0; b_if.obj_pxl = 0;
        b_if.set_fix = 0; b_if.gfx_en = '1; b_if.st_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pal", 32'(a_if.pal_addr), 0);
        chk("rst.sel", 32'(a_if.sel), 0);
        chk("rst.shd", 32'(a_if.shadow), 0);
        for (int i = 0; i < 256; i++) begin
            a_if.st_addr = 8'(i);
            #1;
            chk("rst.st", 32'(a_if.st_dout), 0);
        end
        rst = 1'b0;

        a_if.char_pxl = 7'h01;
        a_if.scr_pxl  = {11'h000, 11'h403};
        chk_a("scr0_wins", 11'h403, 4'b0100, 1'b0);
        a_if.set_fix = 1'b1;
        chk_a("set_fix", 11'h401, 4'b0001, 1'b0);
        a_if.set_fix = 1'b0;

        a_if.obj_pxl = 12'hC12;
        chk_a("obj_p3", 11'h012, 4'b0010, 1'b0);
        a_if.char_pxl = 7'h00;
        a_if.obj_pxl  = 12'h012;
        a_if.scr_pxl  = {11'h005, 11'h000};
        chk_a("scr1_over_obj", 11'h405, 4'b1000, 1'b0);

        a_if.obj_pxl = 12'h81E;
        chk_a("shadow_on", 11'h405, 4'b1000, 1'b1);
        a_if.scr_pxl = {11'h005, 11'h403};
        chk_a("shadow_off", 11'h403, 4'b0100, 1'b0);

        a_if.char_pxl = 7'h01;
        a_if.obj_pxl  = 12'hC12;
        a_if.scr_pxl  = {11'h401, 11'h403};
        a_if.gfx_en   = '0;
        chk_a("backdrop", 11'h400, 4'b0000, 1'b0);
        a_if.gfx_en = '1;

        b_if.char_pxl = 7'h01;
        b_if.scr_pxl  = {11'h401, 33'h0};
        chk_b("tie_fix_scr3", 11'h401, 6'b000001);
        b_if.char_pxl = 7'h00;
        chk_b("scr3_alone", 11'h401, 6'b100000);
        b_if.obj_pxl = 12'h001;
        b_if.scr_pxl = {11'h002, 33'h0};
        chk_b("tie_obj_scr3", 11'h001, 6'b000010);

        a_if.char_pxl = 7'h01; a_if.obj_pxl = 0; a_if.scr_pxl = 0;
        b_if.char_pxl = 7'h01; b_if.obj_pxl = 0; b_if.scr_pxl = 0;
        tick();
        tick();
        a_if.lvbl = 1'b1;
        b_if.lvbl = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) b_if.lvbl = 1'b0;
            tick();
        end
        a_if.lvbl = 1'b0;
        tick();
        a_if.st_addr = 8'd0;  #1; chk("st.fix_b0", 32'(a_if.st_dout), 100);
        a_if.st_addr = 8'd1;  #1; chk("st.fix_b1", 32'(a_if.st_dout), 0);
        a_if.st_addr = 8'd4;  #1; chk("st.obj", 32'(a_if.st_dout), 0);
        a_if.st_addr = 8'd16; #1; chk("st.bkdrop", 32'(a_if.st_dout), 0);
        b_if.st_addr = 8'd0;  #1; chk("st.sat", 32'(b_if.st_dout), 15);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_if.st_addr = 8'd0; #1; chk("st.rst_clr", 32'(a_if.st_dout), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
